// File: rtl/camera_pkg.sv
// camera_pkg: definitions shared by the camera capture front end.
//   cam_state_e   : capture FSM states (IDLE, CAPTURE, FLUSH, DRAIN)
//   CAM_FRAME_LEN : default bytes per frame
//   CAM_DATA_W    : default pixel byte width
package camera_pkg;

  localparam int CAM_FRAME_LEN = 75;
  localparam int CAM_DATA_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DRAIN   = 2'd3
  } cam_state_e;

endpackage : camera_pkg

// File: rtl/camera_frame_buf.sv
// camera_frame_buf: DEPTH x WIDTH register file holding one captured frame.
// One synchronous write port, one asynchronous read port, no reset.
// Ports:
//   clk      in  clock
//   i_we     in  write enable
//   i_waddr  in  write address
//   i_wdata  in  write data
//   i_raddr  in  read address
//   o_rdata  out read data (combinational from i_raddr)
module camera_frame_buf #(
  parameter int DEPTH = 75,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // NOTE: storage arrays are deliberately left without reset; every entry is
  // written before it is read, and a reset would prevent mapping to RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : camera_frame_buf

// File: rtl/camera_capture.sv
// camera_capture: frame-capture front end for the camera source.
// Requests exactly one frame of FRAME_LEN bytes by holding camera_en high for
// FRAME_LEN cycles, stores the returned byte stream in camera_frame_buf, then
// replays the frame on a valid/ready stream with a last-byte marker.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   start               begin a capture (sampled only in IDLE)
//   camera_en           enable to the camera source
//   data_valid, data_in camera byte stream
//   m_valid, m_data,
//   m_last, m_ready     downstream stream
//   busy                high in any state except IDLE
//   frame_done          one-cycle pulse after the final downstream handshake
//   overrun             sticky: camera byte seen outside the capture window
//   frame_sum           mod-2^DATA_W byte sum (only with CAMERA_CAPTURE_SUM_EN)
// Optional feature macro: CAMERA_CAPTURE_SUM_EN
module camera_capture
  import camera_pkg::*;
#(
  parameter int FRAME_LEN = CAM_FRAME_LEN,
  parameter int DATA_W    = CAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              camera_en,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
`ifdef CAMERA_CAPTURE_SUM_EN
  ,
  output logic [DATA_W-1:0] frame_sum
`endif
);

  localparam int               CNT_W  = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LEN    = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(FRAME_LEN - 1);

  cam_state_e        r_state, w_state_next;
  logic [CNT_W-1:0]  r_en_cnt, r_wr_cnt, r_rd_ptr;
  logic              r_m_valid, r_m_last, r_frame_done, r_overrun;
  logic [DATA_W-1:0] r_m_data;

  logic              w_start, w_capturing, w_write, w_drop;
  logic              w_accept, w_accept_last, w_advance, w_load;
  logic [CNT_W-1:0]  w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;

  assign w_start     = (r_state == ST_IDLE) && start;
  assign w_capturing = (r_state == ST_CAPTURE) || (r_state == ST_FLUSH);
  assign w_write     = w_capturing && data_valid && (r_wr_cnt < LEN);
  // Every camera byte that is not stored is an overrun, whatever the state.
  assign w_drop      = data_valid && !w_write;

  assign w_accept      = (r_state == ST_DRAIN) && r_m_valid && m_ready;
  assign w_accept_last = w_accept && (r_rd_ptr == LEN_M1);
  assign w_advance     = w_accept && !w_accept_last;
  // Reload the output register on DRAIN entry and after every non-final
  // handshake, so a byte is offered every cycle under continuous m_ready.
  assign w_load        = (r_state == ST_DRAIN) && (!r_m_valid || w_advance);
  assign w_rd_addr     = w_advance ? r_rd_ptr + 1'b1 : r_rd_ptr;

  camera_frame_buf #(
    .DEPTH (FRAME_LEN),
    .WIDTH (DATA_W),
    .AW    (CNT_W)
  ) u_frame_buf (
    .clk     (clk),
    .i_we    (w_write),
    .i_waddr (r_wr_cnt),
    .i_wdata (data_in),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:    if (start)                 w_state_next = ST_CAPTURE;
      ST_CAPTURE: if (r_en_cnt == LEN_M1)    w_state_next = ST_FLUSH;
      // Leave FLUSH in the same cycle the final byte is written.
      ST_FLUSH:   if ((r_wr_cnt == LEN) || (w_write && (r_wr_cnt == LEN_M1)))
                                             w_state_next = ST_DRAIN;
      ST_DRAIN:   if (w_accept_last)         w_state_next = ST_IDLE;
      default:                               w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_cnt     <= '0;
      r_wr_cnt     <= '0;
      r_rd_ptr     <= '0;
      r_overrun    <= 1'b0;
      r_frame_done <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_last     <= 1'b0;
    end else begin
      r_frame_done <= w_accept_last;

      if (w_start) begin
        r_en_cnt <= '0;
        r_wr_cnt <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (r_state == ST_CAPTURE) r_en_cnt <= r_en_cnt + 1'b1;
        if (w_write)               r_wr_cnt <= r_wr_cnt + 1'b1;
        if (w_advance)             r_rd_ptr <= r_rd_ptr + 1'b1;
      end

      // A byte dropped in the same cycle as start still counts as overrun.
      if (w_drop)       r_overrun <= 1'b1;
      else if (w_start) r_overrun <= 1'b0;

      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_rd_data;
        r_m_last  <= (w_rd_addr == LEN_M1);
      end else if (w_accept_last) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end
    end
  end

`ifdef CAMERA_CAPTURE_SUM_EN
  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_sum <= '0;
    else if (w_start) r_sum <= '0;
    else if (w_write) r_sum <= r_sum + data_in;
  end

  assign frame_sum = r_sum;
`endif

  // camera_en comes straight from the state register so reset drops it at once.
  assign camera_en  = (r_state == ST_CAPTURE);
  assign busy       = (r_state != ST_IDLE);
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign frame_done = r_frame_done;
  assign overrun    = r_overrun;

endmodule : camera_capture
